// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch-unit signals: the start strobe, the instruction-memory read
// port, and the decode/execute handshake.
//   master : the fetch unit. Drives the memory address/strobe, the instruction,
//            the PC values and the status.
//   slave  : the environment (memory, decode/execute, branch unit).
// PC, PC_new and PC_incremented keep their architectural capitalisation.
interface instr_fetch_unit_if #(
    parameter int unsigned IMEM_DEPTH = 1024
);
    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic          start;
    logic [AW-1:0] imem_addr;
    logic          imem_rd_en;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          exec_done;
    logic [31:0]   PC_new;
    logic [31:0]   PC;
    logic [31:0]   PC_incremented;
    logic          halted;
    logic          fault;
    logic [31:0]   retired;

    modport master (
        input  start, imem_rdata, exec_done, PC_new,
        output imem_addr, imem_rd_en, instr, instr_valid,
               PC, PC_incremented, halted, fault, retired
    );

    modport slave (
        output start, imem_rdata, exec_done, PC_new,
        input  imem_addr, imem_rd_en, instr, instr_valid,
               PC, PC_incremented, halted, fault, retired
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC and instruction-fetch stage of the single-cycle KGP-RISC datapath.
// The unit runs IDLE -> FETCH -> WAIT -> EXEC and returns to FETCH for each
// instruction. On a halt instruction or an illegal branch target it goes to HALT,
// which it leaves only on reset.
//   clk, rst      : clock and synchronous active-low reset.
//   bus (master)  : start; imem_addr/imem_rd_en/imem_rdata (synchronous-read
//                   memory, data arrives the cycle after the strobe);
//                   instr/instr_valid/exec_done/PC_new (execute handshake);
//                   PC, PC_incremented, halted, fault, retired.
module instr_fetch_unit #(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_unit_if.master  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, HALT} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   retired_q, retired_d;
    logic [31:0]   instr_q, instr_d;
    logic          halted_q, halted_d;
    logic          fault_q, fault_d;
    logic          rd_en_q, rd_en_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          target_bad;

    // A target is illegal if it is misaligned or if it points past the end of
    // the instruction memory.
    assign target_bad = (bus.PC_new[1:0] != 2'b00) ||
                        ({2'b00, bus.PC_new[31:2]} >= 32'(IMEM_DEPTH));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        instr_d   = instr_q;
        halted_d  = halted_q;
        fault_d   = fault_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = FETCH;
            FETCH: state_d = WAIT;
            WAIT: begin
                if (bus.imem_rdata == HALT_INSTR) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    instr_d = bus.imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (bus.exec_done) begin
                    // On a faulting target the PC still takes PC_new, so that
                    // the bad target can be seen when debugging.
                    pc_d      = bus.PC_new;
                    retired_d = retired_q + 32'd1;
                    if (target_bad) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = HALT;
        endcase
        // Outputs are registered from the next state. This puts them in step
        // with the state they describe.
        rd_en_d = (state_d == FETCH);
        valid_d = (state_d == EXEC);
        addr_d  = (state_d == FETCH) ? pc_d[AW+1:2] : addr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            retired_q <= 32'd0;
            instr_q   <= 32'd0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            addr_q    <= RESET_PC[AW+1:2];
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            instr_q   <= instr_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
            rd_en_q   <= rd_en_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
        end
    end

    assign bus.imem_addr      = addr_q;
    assign bus.imem_rd_en     = rd_en_q;
    assign bus.instr          = instr_q;
    assign bus.instr_valid    = valid_q;
    assign bus.PC             = pc_q;
    assign bus.PC_incremented = pc_q + 32'd4;
    assign bus.halted         = halted_q;
    assign bus.fault          = fault_q;
    assign bus.retired        = retired_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. Directed scenarios come first, then random
// episodes. A memory model and an instruction-level reference model (expected
// PC, retired count and status flags) supply every expected value.
module tb_instr_fetch_unit;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    instr_fetch_unit_if #(.IMEM_DEPTH(DEPTH)) bus ();

    instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .HALT_INSTR(HALT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read instruction memory.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];

    // Reference state, kept at the instruction level.
    logic [31:0] exp_pc, exp_ret, exp_instr;
    logic        exp_halted, exp_fault;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic bit legal(input logic [31:0] a);
        return (a % 32'd4 == 32'd0) && ((a / 32'd4) < 32'(DEPTH));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        exp_pc = 32'h0; exp_ret = 32'h0; exp_instr = 32'h0;
        exp_halted = 1'b0; exp_fault = 1'b0;
        chk({tag, ".pc"},      bus.PC, 32'h0);
        chk({tag, ".pcinc"},   bus.PC_incremented, 32'h4);
        chk({tag, ".instr"},   bus.instr, 32'h0);
        chk({tag, ".valid"},   32'(bus.instr_valid), 32'd0);
        chk({tag, ".rd_en"},   32'(bus.imem_rd_en), 32'd0);
        chk({tag, ".addr"},    32'(bus.imem_addr), 32'd0);
        chk({tag, ".halted"},  32'(bus.halted), 32'd0);
        chk({tag, ".fault"},   32'(bus.fault), 32'd0);
        chk({tag, ".retired"}, bus.retired, 32'd0);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        check_reset("reset");
    endtask

    // Called in the FETCH cycle. Returns in the EXEC cycle, or in the first
    // cycle after the unit halts.
    task automatic fetch_phase;
        int idx;
        idx = int'(exp_pc / 32'd4) % DEPTH;
        chk("fetch.rd_en", 32'(bus.imem_rd_en), 32'd1);
        chk("fetch.addr",  32'(bus.imem_addr), 32'(idx));
        chk("fetch.valid", 32'(bus.instr_valid), 32'd0);
        tick;
        chk("wait.rd_en",  32'(bus.imem_rd_en), 32'd0);
        chk("wait.valid",  32'(bus.instr_valid), 32'd0);
        tick;
        if (mem[idx] == HALT) begin
            exp_halted = 1'b1;
            chk("hlt.halted",  32'(bus.halted), 32'd1);
            chk("hlt.fault",   32'(bus.fault), 32'(exp_fault));
            chk("hlt.valid",   32'(bus.instr_valid), 32'd0);
            chk("hlt.retired", bus.retired, exp_ret);
        end else begin
            exp_instr = mem[idx];
            chk("exec.valid", 32'(bus.instr_valid), 32'd1);
            chk("exec.instr", bus.instr, exp_instr);
            chk("exec.pc",    bus.PC, exp_pc);
        end
    endtask

    task automatic do_start;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        fetch_phase();
    endtask

    // Called in an EXEC cycle. Waits dly cycles, then completes the
    // instruction with the given next PC.
    task automatic do_exec(input logic [31:0] nxt, input int dly);
        for (int i = 0; i < dly; i++) begin
            tick;
            chk("hold.valid", 32'(bus.instr_valid), 32'd1);
            chk("hold.instr", bus.instr, exp_instr);
            chk("hold.pc",    bus.PC, exp_pc);
        end
        bus.exec_done = 1'b1;
        bus.PC_new    = nxt;
        tick;
        bus.exec_done = 1'b0;
        bus.PC_new    = $urandom;
        exp_ret = exp_ret + 32'd1;
        exp_pc  = nxt;
        chk("done.valid",   32'(bus.instr_valid), 32'd0);
        chk("done.pc",      bus.PC, exp_pc);
        chk("done.pcinc",   bus.PC_incremented, exp_pc + 32'd4);
        chk("done.retired", bus.retired, exp_ret);
        if (!legal(nxt)) begin
            exp_halted = 1'b1;
            exp_fault  = 1'b1;
            chk("flt.halted", 32'(bus.halted), 32'd1);
            chk("flt.fault",  32'(bus.fault), 32'd1);
            chk("flt.rd_en",  32'(bus.imem_rd_en), 32'd0);
        end else begin
            fetch_phase();
        end
    endtask

    initial begin
        int t0;
        logic [31:0] nxt;
        bus.start = 1'b0;
        bus.exec_done = 1'b0;
        bus.PC_new = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = 32'h0;
        end

        // Reset, start latency, sequential stream, branch.
        do_reset();
        do_start();
        t0 = cyc;
        do_exec(exp_pc + 32'd4, 0);
        chk("seq.cycles", 32'(cyc - t0), 32'd3);
        do_exec(exp_pc + 32'd4, 0);
        chk("seq.pc8", bus.PC, 32'h8);
        do_exec(32'h40, 0);
        chk("br.addr",    32'(bus.imem_addr), 32'd16);
        chk("br.instr",   bus.instr, mem[16]);
        chk("br.retired", bus.retired, 32'd3);

        // Halt instruction at word 1; later inputs must be ignored.
        do_reset();
        mem[1] = HALT;
        do_start();
        do_exec(32'h4, 1);
        chk("halt.retired", bus.retired, 32'd1);
        bus.start = 1'b1;
        bus.exec_done = 1'b1;
        bus.PC_new = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("halt.hold.valid",  32'(bus.instr_valid), 32'd0);
            chk("halt.hold.rd_en",  32'(bus.imem_rd_en), 32'd0);
            chk("halt.hold.halted", 32'(bus.halted), 32'd1);
            chk("halt.hold.fault",  32'(bus.fault), 32'd0);
            chk("halt.hold.ret",    bus.retired, 32'd1);
            chk("halt.hold.pc",     bus.PC, 32'h4);
        end
        bus.start = 1'b0;
        bus.exec_done = 1'b0;
        mem[1] = 32'h1234_5678;

        // Fault cases: a misaligned target, a target one word past the end,
        // and the PC_incremented wrap.
        do_reset();
        do_start();
        do_exec(32'h6, 0);
        chk("flt6.pc", bus.PC, 32'h6);
        do_reset();
        do_start();
        do_exec(32'h1000, 2);
        chk("flt1000.fault", 32'(bus.fault), 32'd1);
        do_reset();
        do_start();
        do_exec(32'hFFFF_FFFC, 0);
        chk("wrap.pcinc", bus.PC_incremented, 32'h0);

        // Reset during WAIT, then during EXEC with exec_done pending.
        do_reset();
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check_reset("rst_wait");
        tick;
        chk("rst_wait.idle.valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_wait.idle.rd_en", 32'(bus.imem_rd_en), 32'd0);
        do_start();
        bus.exec_done = 1'b1;
        bus.PC_new = 32'h40;
        rst = 1'b0;
        tick;
        bus.exec_done = 1'b0;
        rst = 1'b1;
        check_reset("rst_exec");
        tick;
        chk("rst_exec.idle.valid", 32'(bus.instr_valid), 32'd0);

        // Random episodes with sparse halt words and mixed targets.
        for (int ep = 0; ep < 6; ep++) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] = ($urandom_range(0, 39) == 0) ? HALT : $urandom;
            do_reset();
            do_start();
            for (int k = 0; k < 40 && !exp_halted; k++) begin
                case ($urandom_range(0, 11))
                    0:       nxt = $urandom;
                    1, 2, 3: nxt = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
                    default: nxt = exp_pc + 32'd4;
                endcase
                do_exec(nxt, int'($urandom_range(0, 2)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
